// File: rtl/seq_pkg.sv
// Shared types and constants for the SEQ Y86-64 stage sequencer.
// Includes the stage-state enum, icode/status encodings and icode routing helpers.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEMORY,
        ST_WRITEBACK,
        ST_PCUPD,
        ST_HALT
    } seq_state_t;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_CMOVXX = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    function automatic logic needs_mem(input logic [3:0] icode);
        case (icode)
            ICODE_RMMOVQ, ICODE_MRMOVQ, ICODE_CALL,
            ICODE_RET, ICODE_PUSHQ, ICODE_POPQ: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // True for every icode that writes the register file, including those
    // that pass through MEMORY first; rmmovq is the only memory op without it.
    function automatic logic needs_wb(input logic [3:0] icode);
        case (icode)
            ICODE_CMOVXX, ICODE_IRMOVQ, ICODE_OPQ, ICODE_MRMOVQ,
            ICODE_CALL, ICODE_RET, ICODE_PUSHQ, ICODE_POPQ: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_perf_cnt.sv
// Free-running busy-cycle and retired-instruction counters.
// Both counters wrap silently at 2^CNT_W.
module seq_perf_cnt #(
    parameter int CNT_W = 64
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             count_cycle,
    input  logic             count_retire,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (count_cycle)
                cycle_cnt <= cycle_cnt + CNT_ONE;
            if (count_retire)
                instr_cnt <= instr_cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/seq_stage_controller.sv
// Multi-cycle stage sequencer for the SEQ Y86-64 core: one-cycle stage strobes,
// imem/dmem handshakes, processor status and performance counters.
//
// state        | meaning
// IDLE         | waiting for start
// FETCH        | imem_req high until imem_ack
// DECODE       | dec_en strobe
// EXECUTE      | exe_en strobe, route by icode
// MEMORY       | dmem_req high until dmem_ack
// WRITEBACK    | wb_en strobe
// PCUPD        | pc_en strobe, instruction retires
// HALT         | absorbing, stat holds the cause
module seq_stage_controller
    import seq_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic             imem_err,
    output logic             dmem_req,
    input  logic             dmem_ack,
    input  logic             dmem_err,
    output logic             dec_en,
    output logic             exe_en,
    output logic             wb_en,
    output logic             pc_en,
    output logic [2:0]       stat,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    seq_state_t state, state_nxt;
    logic [3:0] icode_q, icode_nxt;
    logic [2:0] stat_q, stat_nxt;
    logic       retire;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state   <= ST_IDLE;
            icode_q <= ICODE_HALT;
            stat_q  <= STAT_AOK;
        end else begin
            state   <= state_nxt;
            icode_q <= icode_nxt;
            stat_q  <= stat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        icode_nxt = icode_q;
        stat_nxt  = stat_q;
        retire    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start)
                    state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    if (imem_err) begin
                        stat_nxt  = STAT_ADR;
                        state_nxt = ST_HALT;
                    end else if (!instr_valid) begin
                        stat_nxt  = STAT_INS;
                        state_nxt = ST_HALT;
                    end else if (icode == ICODE_HALT) begin
                        stat_nxt  = STAT_HLT;
                        retire    = 1'b1;
                        state_nxt = ST_HALT;
                    end else begin
                        icode_nxt = icode;
                        state_nxt = ST_DECODE;
                    end
                end
            end
            ST_DECODE: state_nxt = ST_EXECUTE;
            ST_EXECUTE: begin
                if (needs_mem(icode_q))
                    state_nxt = ST_MEMORY;
                else if (needs_wb(icode_q))
                    state_nxt = ST_WRITEBACK;
                else
                    state_nxt = ST_PCUPD;
            end
            ST_MEMORY: begin
                if (dmem_ack) begin
                    if (dmem_err) begin
                        stat_nxt  = STAT_ADR;
                        state_nxt = ST_HALT;
                    end else if (needs_wb(icode_q)) begin
                        state_nxt = ST_WRITEBACK;
                    end else begin
                        state_nxt = ST_PCUPD;
                    end
                end
            end
            ST_WRITEBACK: state_nxt = ST_PCUPD;
            ST_PCUPD: begin
                retire    = 1'b1;
                state_nxt = ST_FETCH;
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Everything visible is decoded from registered state so no output
    // has a combinational path from the memory handshake inputs.
    assign imem_req = (state == ST_FETCH);
    assign dmem_req = (state == ST_MEMORY);
    assign dec_en   = (state == ST_DECODE);
    assign exe_en   = (state == ST_EXECUTE);
    assign wb_en    = (state == ST_WRITEBACK);
    assign pc_en    = (state == ST_PCUPD);
    assign halted   = (state == ST_HALT);
    assign busy     = (state != ST_IDLE) && (state != ST_HALT);
    assign stat     = stat_q;

    seq_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .count_cycle  (busy),
        .count_retire (retire),
        .cycle_cnt    (cycle_cnt),
        .instr_cnt    (instr_cnt)
    );

endmodule

// File: tb/tb_seq_stage_controller.sv
// Scoreboard bench for seq_stage_controller: stimulus pushes expected pc_en / halt
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_seq_stage_controller;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  icode = 4'hF;
    logic        instr_valid = 1'b0;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic        imem_err = 1'b0;
    logic        dmem_req;
    logic        dmem_ack = 1'b0;
    logic        dmem_err = 1'b0;
    logic        dec_en, exe_en, wb_en, pc_en;
    logic [2:0]  stat;
    logic        busy, halted;
    logic [63:0] cycle_cnt, instr_cnt;

    seq_stage_controller #(.CNT_W(64)) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .start       (start),
        .icode       (icode),
        .instr_valid (instr_valid),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .imem_err    (imem_err),
        .dmem_req    (dmem_req),
        .dmem_ack    (dmem_ack),
        .dmem_err    (dmem_err),
        .dec_en      (dec_en),
        .exe_en      (exe_en),
        .wb_en       (wb_en),
        .pc_en       (pc_en),
        .stat        (stat),
        .busy        (busy),
        .halted      (halted),
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
    );

    always #5 Clk = ~Clk;

    int tb_cyc = 0;
    always @(posedge Clk) tb_cyc <= tb_cyc + 1;

    typedef struct {
        logic        is_halt;
        int          cyc;
        logic [2:0]  stat;
        logic [63:0] icnt;
        logic [63:0] ccnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   mret = 0;
    int   mcyc = 0;
    logic halted_d = 1'b0;

    task automatic chk64(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        chk64(nm, {63'd0, got}, {63'd0, exp});
    endtask

    // Monitor: every pc_en cycle and every entry into HALT must match the oldest expectation.
    always @(negedge Clk) begin
        exp_t e;
        logic hev;
        hev = halted && !halted_d;
        if (Rst_n && (pc_en || hev)) begin
            if (sb.size() == 0) begin
                chk1("unexpected_event", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                chk1("event_kind", hev, e.is_halt);
                chk64("event_cycle", 64'(tb_cyc), 64'(e.cyc));
                chk64("event_stat", 64'(stat), 64'(e.stat));
                chk64("event_instr_cnt", instr_cnt, e.icnt);
                chk64("event_cycle_cnt", cycle_cnt, e.ccnt);
            end
        end
        halted_d = halted;
    end

    task automatic push_exp(input logic h, input int cyc, input logic [2:0] st,
                            input int icnt, input int ccnt);
        exp_t e;
        e.is_halt = h;
        e.cyc     = cyc;
        e.stat    = st;
        e.icnt    = 64'(icnt);
        e.ccnt    = 64'(ccnt);
        sb.push_back(e);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk64({nm, "_stat"}, 64'(stat), 64'd1);
        chk64({nm, "_cycle_cnt"}, cycle_cnt, 64'd0);
        chk64({nm, "_instr_cnt"}, instr_cnt, 64'd0);
        chk64({nm, "_ctl"}, 64'({imem_req, dmem_req, dec_en, exe_en, wb_en, pc_en, busy, halted}), 64'd0);
    endtask

    task automatic do_reset();
        Rst_n    = 1'b0;
        start    = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk_reset_vals("reset");
        Rst_n = 1'b1;
        start = 1'b0;
        mret  = 0;
        mcyc  = 0;
    endtask

    task automatic start_run();
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

    // One instruction: iw / dw are ack wait cycles for fetch / memory.
    task automatic run_instr(input logic [3:0] ic, input logic vld, input logic ierr,
                             input int iw, input int dw, input logic derr);
        int f0, n;
        logic mem;
        for (int to = 0; to < 20 && !imem_req; to++) @(negedge Clk);
        chk1("fetch_seen", imem_req, 1'b1);
        if (!imem_req) return;
        f0  = tb_cyc;
        mem = (ic == 4'h4 || ic == 4'h5 || ic == 4'h8 || ic == 4'h9 || ic == 4'hA || ic == 4'hB);
        n   = 0;
        if (ierr)
            push_exp(1'b1, f0 + iw + 1, 3'd3, mret, mcyc + iw + 1);
        else if (!vld)
            push_exp(1'b1, f0 + iw + 1, 3'd4, mret, mcyc + iw + 1);
        else if (ic == 4'h0)
            push_exp(1'b1, f0 + iw + 1, 3'd2, mret + 1, mcyc + iw + 1);
        else if (mem && derr)
            push_exp(1'b1, f0 + iw + 4 + dw, 3'd3, mret, mcyc + iw + 4 + dw);
        else begin
            if (ic == 4'h1 || ic == 4'h7)      n = iw + 3;
            else if (!mem)                     n = iw + 4;
            else if (ic == 4'h4)               n = iw + 4 + dw;
            else                               n = iw + 5 + dw;
            push_exp(1'b0, f0 + n, 3'd1, mret, mcyc + n);
            mret = mret + 1;
            mcyc = mcyc + n + 1;
        end

        for (int i = 0; i < iw; i++) begin
            chk1("imem_req_hold", imem_req, 1'b1);
            @(negedge Clk);
        end
        icode       = ic;
        instr_valid = vld;
        imem_err    = ierr;
        imem_ack    = 1'b1;
        @(negedge Clk);
        imem_ack    = 1'b0;
        imem_err    = 1'b0;
        instr_valid = 1'b0;
        icode       = 4'hF;
        chk1("imem_req_drop", imem_req, 1'b0);
        if (ierr || !vld || ic == 4'h0) begin
            chk1("no_dec_on_halt", dec_en, 1'b0);
            chk1("halted_after_fetch", halted, 1'b1);
            return;
        end
        chk1("dec_en", dec_en, 1'b1);
        @(negedge Clk);
        chk1("exe_en", exe_en, 1'b1);
        if (!mem) begin
            if (ic != 4'h1 && ic != 4'h7) begin
                @(negedge Clk);
                chk1("wb_en", wb_en, 1'b1);
            end
            return;
        end
        @(negedge Clk);
        for (int i = 0; i < dw; i++) begin
            chk1("dmem_req_hold", dmem_req, 1'b1);
            @(negedge Clk);
        end
        chk1("dmem_req_last", dmem_req, 1'b1);
        dmem_ack = 1'b1;
        dmem_err = derr;
        @(negedge Clk);
        dmem_ack = 1'b0;
        dmem_err = 1'b0;
        chk1("dmem_req_drop", dmem_req, 1'b0);
        if (derr)
            chk1("halted_after_dmem_err", halted, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        @(negedge Clk);
        @(negedge Clk);
        chk1("idle_without_start", busy, 1'b0);

        start_run();
        run_instr(4'h6, 1'b1, 1'b0, 0, 0, 1'b0);
        run_instr(4'h5, 1'b1, 1'b0, 0, 3, 1'b0);
        run_instr(4'h7, 1'b1, 1'b0, 0, 0, 1'b0);
        run_instr(4'h4, 1'b1, 1'b0, 1, 0, 1'b0);
        run_instr(4'h2, 1'b1, 1'b0, 2, 0, 1'b0);
        run_instr(4'h9, 1'b1, 1'b0, 0, 1, 1'b0);
        run_instr(4'h1, 1'b1, 1'b0, 0, 0, 1'b0);
        run_instr(4'h3, 1'b1, 1'b0, 0, 0, 1'b0);
        run_instr(4'hB, 1'b1, 1'b0, 0, 0, 1'b0);
        run_instr(4'h8, 1'b1, 1'b0, 0, 2, 1'b0);
        run_instr(4'hA, 1'b1, 1'b0, 0, 0, 1'b0);
        run_instr(4'h0, 1'b1, 1'b1, 1, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            start = i[0];
            @(negedge Clk);
            chk1("halt_hold", halted, 1'b1);
            chk64("halt_hold_stat", 64'(stat), 64'd3);
            chk1("halt_not_busy", busy, 1'b0);
        end
        start = 1'b0;

        do_reset();
        start_run();
        run_instr(4'h0, 1'b1, 1'b0, 0, 0, 1'b0);
        @(negedge Clk);
        chk64("hlt_retired", instr_cnt, 64'd1);
        chk64("hlt_stat", 64'(stat), 64'd2);

        do_reset();
        start_run();
        run_instr(4'h0, 1'b0, 1'b0, 0, 0, 1'b0);
        @(negedge Clk);
        chk64("ins_stat", 64'(stat), 64'd4);
        chk64("ins_not_retired", instr_cnt, 64'd0);

        do_reset();
        start_run();
        run_instr(4'h6, 1'b1, 1'b0, 0, 0, 1'b0);
        run_instr(4'h9, 1'b1, 1'b0, 0, 2, 1'b1);
        repeat (3) @(negedge Clk);
        chk64("adr_dmem_stat", 64'(stat), 64'd3);
        chk64("adr_dmem_instr_cnt", instr_cnt, 64'd1);

        do_reset();
        start_run();
        for (int to = 0; to < 20 && !imem_req; to++) @(negedge Clk);
        chk1("mid_fetch_seen", imem_req, 1'b1);
        icode       = 4'h5;
        instr_valid = 1'b1;
        imem_ack    = 1'b1;
        @(negedge Clk);
        imem_ack    = 1'b0;
        instr_valid = 1'b0;
        for (int to = 0; to < 20 && !dmem_req; to++) @(negedge Clk);
        chk1("mid_mem_seen", dmem_req, 1'b1);
        Rst_n = 1'b0;
        start = 1'b1;
        @(negedge Clk);
        chk_reset_vals("mid_mem_reset");
        Rst_n    = 1'b1;
        start    = 1'b0;
        dmem_ack = 1'b1;
        imem_ack = 1'b1;
        @(negedge Clk);
        dmem_ack = 1'b0;
        imem_ack = 1'b0;
        chk1("stray_ack_busy", busy, 1'b0);
        chk1("stray_ack_dmem_req", dmem_req, 1'b0);
        @(negedge Clk);
        chk1("stray_ack_imem_req", imem_req, 1'b0);
        chk64("stray_ack_cycle_cnt", cycle_cnt, 64'd0);

        repeat (3) @(negedge Clk);
        chk64("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
